// File: rtl/counter_snapshot_serializer_pkg.sv
// Shared types and constants for the counter snapshot serializer.
// Frame layout: header, Count0 bytes, Count1 bytes, XOR checksum.
package counter_snapshot_serializer_pkg;

    localparam int         CNT_W_DEF  = 64;
    localparam int         NB_DEF     = CNT_W_DEF / 8;
    localparam logic [7:0] HEADER_DEF = 8'hA5;
    localparam int         FRAME_LEN  = 2 * NB_DEF + 2;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        SUM
    } state_t;

    function automatic int frame_len(input int cnt_w);
        return 2 * (cnt_w / 8) + 2;
    endfunction

endpackage

// File: rtl/counter_snapshot_serializer_if.sv
// Byte stream valid/ready bundle from the serializer to a byte sink.
// Last flags the checksum byte that ends each frame.
interface counter_snapshot_serializer_if;

    logic [7:0] Data;
    logic       Valid;
    logic       Last;
    logic       Ready;

    modport master (
        output Data,
        output Valid,
        output Last,
        input  Ready
    );

    modport slave (
        input  Data,
        input  Valid,
        input  Last,
        output Ready
    );

endinterface

// File: rtl/counter_snapshot_serializer_snap_byte_sel.sv
// Picks byte k out of the snapshot shadow, little-endian.
// Indices past the last byte return zero.
module snap_byte_sel #(
    parameter int CNT_W = 64,
    parameter int IW    = 5
) (
    input  logic [2*CNT_W-1:0] shadow,
    input  logic [IW-1:0]      idx,
    output logic [7:0]         byte_o
);

    localparam int NB = CNT_W / 8;

    // One-hot compare against every legal byte position
    always_comb begin
        byte_o = 8'h00;
        for (int i = 0; i < 2 * NB; i++) begin
            if (idx == IW'(i)) begin
                byte_o = shadow[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/counter_snapshot_serializer.sv
// Snapshots two counters and streams them as a checksummed byte frame.
// A Snap arriving with the final accept chains straight into a new frame.
module counter_snapshot_serializer
    import counter_snapshot_serializer_pkg::*;
#(
    parameter int         CNT_W  = CNT_W_DEF,
    parameter logic [7:0] HEADER = HEADER_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Snap,
    input  logic [CNT_W-1:0] Count0,
    input  logic [CNT_W-1:0] Count1,
    input  logic             ClrOvr,
    output logic             Busy,
    output logic             Overrun,
    counter_snapshot_serializer_if.master bus
);

    localparam int NB = CNT_W / 8;
    localparam int IW = $clog2(2 * NB) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * NB - 1);

    state_t             state_q, state_d;
    logic [2*CNT_W-1:0] shadow_q, shadow_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [7:0]         sum_q, sum_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;

    logic               accept;
    logic               take;
    logic               dropped;
    logic [IW-1:0]      sel_idx;
    logic [7:0]         sel_byte;

    // Look ahead to the byte that will be presented after this accept
    always_comb begin
        sel_idx = (state_q == HDR) ? '0 : idx_q + IW'(1);
    end

    snap_byte_sel #(
        .CNT_W (CNT_W),
        .IW    (IW)
    ) u_sel (
        .shadow (shadow_q),
        .idx    (sel_idx),
        .byte_o (sel_byte)
    );

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        ovr_d    = ovr_q;
        take     = 1'b0;
        accept   = valid_q && bus.Ready;

        unique case (state_q)
            IDLE: begin
                if (Snap) begin
                    take = 1'b1;
                end
            end
            HDR: begin
                if (accept) begin
                    state_d = DATA;
                    idx_d   = '0;
                    data_d  = sel_byte;
                end
            end
            DATA: begin
                if (accept) begin
                    sum_d = sum_q ^ data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = SUM;
                        data_d  = sum_q ^ data_q;
                        last_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + IW'(1);
                        data_d = sel_byte;
                    end
                end
            end
            SUM: begin
                if (accept) begin
                    if (Snap) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = 8'h00;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        dropped = Snap && (state_q != IDLE) &&
                  !((state_q == SUM) && accept);

        if (take) begin
            shadow_d = {Count1, Count0};
            sum_d    = 8'h00;
            idx_d    = '0;
            state_d  = HDR;
            valid_d  = 1'b1;
            last_d   = 1'b0;
            data_d   = HEADER;
        end

        if (dropped) begin
            ovr_d = 1'b1;
        end else if (ClrOvr) begin
            ovr_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            sum_q    <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.Data  = data_q;
    assign bus.Valid = valid_q;
    assign bus.Last  = last_q;
    assign Busy      = busy_q;
    assign Overrun   = ovr_q;

endmodule

// File: tb/tb_counter_snapshot_serializer.sv
// Bench for counter_snapshot_serializer: table frames, random frames,
// overrun, back-to-back and mid-frame reset sequences.
module tb_counter_snapshot_serializer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Snap;
    logic        ClrOvr;
    logic        Busy;
    logic        Overrun;
    logic [63:0] Count0;
    logic [63:0] Count1;

    counter_snapshot_serializer_if bus();

    counter_snapshot_serializer dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Snap    (Snap),
        .Count0  (Count0),
        .Count1  (Count1),
        .ClrOvr  (ClrOvr),
        .Busy    (Busy),
        .Overrun (Overrun),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [63:0] c0;
        logic [63:0] c1;
        int          mode;
        int          exp_sum;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference frame: header, c0 bytes LSB first, c1 bytes, XOR of data
    function automatic void build(input logic [63:0] c0,
                                  input logic [63:0] c1);
        logic [127:0] all;
        logic [7:0]   s;
        all = {c1, c0};
        s = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(all[8*i +: 8]);
            s = s ^ all[8*i +: 8];
        end
        exp_q.push_back(s);
    endfunction

    task automatic start_frame(input logic [63:0] c0, input logic [63:0] c1);
        @(negedge Clk);
        Snap   = 1'b1;
        Count0 = c0;
        Count1 = c1;
    endtask

    task automatic stream(input logic [63:0] c0, input logic [63:0] c1,
                          input int mode, input int exp_sum,
                          input int snap_at, input bit clr_with_snap,
                          input int abort_at, input bit chain,
                          input logic [63:0] nc0, input logic [63:0] nc1);
        int         k = 0;
        int         n;
        bit         done = 1'b0;
        bit         stall = 1'b0;
        bit         tog = 1'b1;
        bit         snapped = 1'b0;
        bit         rdy;
        logic [7:0] pd;
        logic       pl;
        logic [7:0] es;
        build(c0, c1);
        n = exp_q.size();
        es = exp_sum[7:0];
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge Clk);
            Snap   = 1'b0;
            ClrOvr = 1'b0;
            if (stall) begin
                check("hold_data", bus.Data, pd);
                check("hold_last", bus.Last, pl);
            end
            check("valid", bus.Valid, 1);
            check("busy", Busy, 1);
            if (abort_at >= 0 && k == abort_at) begin
                Reset     = 1'b1;
                bus.Ready = 1'b1;
                done      = 1'b1;
            end else begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       begin rdy = tog; tog = !tog; end
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                bus.Ready = rdy;
                Count0 = {$urandom, $urandom};
                Count1 = {$urandom, $urandom};
                stall = bus.Valid && !rdy;
                pd = bus.Data;
                pl = bus.Last;
                if (snap_at >= 0 && k == snap_at && !snapped) begin
                    Snap    = 1'b1;
                    ClrOvr  = clr_with_snap;
                    snapped = 1'b1;
                end
                if (bus.Valid && rdy) begin
                    check($sformatf("byte%0d", k), bus.Data, exp_q[k]);
                    check($sformatf("last%0d", k), bus.Last, k == n - 1);
                    if (k == n - 1) begin
                        done = 1'b1;
                        if (exp_sum >= 0) check("checksum", bus.Data, es);
                        if (chain) begin
                            Snap   = 1'b1;
                            Count0 = nc0;
                            Count1 = nc1;
                        end
                    end
                    k++;
                end
            end
        end
        if (!done) check("frame_timeout", 0, 1);
        @(negedge Clk);
        Snap      = 1'b0;
        ClrOvr    = 1'b0;
        bus.Ready = 1'b0;
        if (abort_at >= 0) begin
            Reset = 1'b0;
            check("rst_valid", bus.Valid, 0);
            check("rst_busy", Busy, 0);
            check("rst_ovr", Overrun, 0);
        end else if (chain) begin
            check("chain_valid", bus.Valid, 1);
            check("chain_hdr", bus.Data, 8'hA5);
            check("chain_busy", Busy, 1);
            check("chain_ovr", Overrun, 0);
        end else begin
            check("end_valid", bus.Valid, 0);
            check("end_busy", Busy, 0);
        end
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        Reset     = 1'b1;
        Snap      = 1'b0;
        ClrOvr    = 1'b0;
        Count0    = '0;
        Count1    = '0;
        bus.Ready = 1'b0;

        vecs[0] = '{64'h3, 64'h1, 0, 8'h02};
        vecs[1] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1, 8'h00};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 2, 8'h00};
        vecs[3] = '{64'h80, 64'h0, 0, 8'h80};

        repeat (3) @(negedge Clk);
        check("rst_valid0", bus.Valid, 0);
        check("rst_data0", bus.Data, 0);
        check("rst_last0", bus.Last, 0);
        check("rst_busy0", Busy, 0);
        check("rst_ovr0", Overrun, 0);
        Reset = 1'b0;
        @(negedge Clk);
        check("idle_valid", bus.Valid, 0);

        for (int v = 0; v < 4; v++) begin
            start_frame(vecs[v].c0, vecs[v].c1);
            stream(vecs[v].c0, vecs[v].c1, vecs[v].mode, vecs[v].exp_sum,
                   -1, 1'b0, -1, 1'b0, '0, '0);
        end

        for (int r = 0; r < 3; r++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            start_frame(ra, rb);
            stream(ra, rb, 2, -1, -1, 1'b0, -1, 1'b0, '0, '0);
        end
        check("ovr_none", Overrun, 0);

        start_frame(64'h1111, 64'h2222);
        stream(64'h1111, 64'h2222, 0, -1, 5, 1'b0, -1, 1'b0, '0, '0);
        check("ovr_set", Overrun, 1);
        @(negedge Clk);
        ClrOvr = 1'b1;
        @(negedge Clk);
        ClrOvr = 1'b0;
        check("ovr_clr", Overrun, 0);

        ra = 64'hDEADBEEFCAFEF00D;
        rb = 64'h0F1E2D3C4B5A6978;
        start_frame(64'h55, 64'hAA);
        stream(64'h55, 64'hAA, 0, 8'hFF, -1, 1'b0, -1, 1'b1, ra, rb);
        stream(ra, rb, 1, -1, -1, 1'b0, -1, 1'b0, '0, '0);
        check("chain_ovr_end", Overrun, 0);

        start_frame(64'h7, 64'h9);
        stream(64'h7, 64'h9, 0, 8'h0E, 3, 1'b1, -1, 1'b0, '0, '0);
        check("ovr_set_wins", Overrun, 1);

        start_frame(64'hABCD, 64'h1234);
        stream(64'hABCD, 64'h1234, 0, -1, -1, 1'b0, 9, 1'b0, '0, '0);
        start_frame(64'h42, 64'h24);
        stream(64'h42, 64'h24, 0, 8'h66, -1, 1'b0, -1, 1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_snapshot_serializer.md
Name: counter_snapshot_serializer

Overview:
- Downstream consumer of the dual 64-bit event counters; takes a coherent snapshot of both counter outputs on request.
- Streams the snapshot as a framed byte sequence over a valid/ready interface: header, Count0 bytes, Count1 bytes, XOR checksum.
- Feeds the UART/debug byte sink so counter values can be read off-board without stopping the counters.

Parameters:
- CNT_W, 64, width of each counter input; must be a multiple of 8 (NB = CNT_W/8 bytes per counter).
- HEADER, 8'hA5, first byte of every frame.

Ports:
- Clk  input  1  system clock, all state on posedge
- Reset  input  1  synchronous, active-high reset
- Snap  input  1  snapshot request, sampled each cycle
- Count0  input  CNT_W  counter 0 value (from counter block Output0)
- Count1  input  CNT_W  counter 1 value (from counter block Output1)
- Ready  input  1  sink accepts Data this cycle when Valid&&Ready
- ClrOvr  input  1  clears Overrun
- Data  output  8  current frame byte
- Valid  output  1  Data is valid
- Last  output  1  high with the checksum byte
- Busy  output  1  frame in progress (state != IDLE)
- Overrun  output  1  sticky: a Snap was dropped

Behaviour:
- Reset (synchronous, dominates all inputs): state=IDLE, Valid=0, Data=0, Last=0, Busy=0, Overrun=0, shadow regs=0, byte index=0, checksum=0. Reset mid-frame aborts the frame; no partial completion. Valid is 0 after the reset edge.
- All outputs are registered.
- States: IDLE, HDR, DATA, SUM.
- IDLE:
  - On Snap=1, latch {Count1,Count0} into the 2*CNT_W shadow, clear checksum and index, go to HDR.
  - Next cycle: Valid=1, Data=HEADER. Latency from Snap to first Valid is 1 cycle.
- HDR: on Valid&&Ready, go to DATA with index=0.
- DATA:
  - Byte k (0..2*NB-1) is shadow[8k+7:8k], little-endian, Count0 before Count1.
  - On each accept, checksum ^= byte and index increments.
  - After byte 2*NB-1 is accepted, go to SUM.
- SUM: Data = XOR of all 2*NB data bytes (header excluded), Last=1. On accept, go to IDLE.
- Frame length is 2*NB+2 bytes (18 at default CNT_W).
- Handshake:
  - While Valid&&!Ready, Data, Last and Valid hold stable.
  - Valid never drops without an accept except on Reset.
  - Ready may be held high continuously; this gives one byte per cycle and no bubbles inside a frame.
- Snapshot coherency: Count0/Count1 are sampled only on the accepting Snap edge. Counter changes during the frame do not affect it.
- Snap while Busy: ignored and sets Overrun=1.
  - Exception: Snap on the same cycle the SUM byte is accepted is taken as a new request. Shadow is latched, next state is HDR, Overrun is unchanged, and there is 0 idle cycles between frames.
- Overrun:
  - Cleared by ClrOvr.
  - If ClrOvr and a dropped Snap occur in the same cycle, set wins (Overrun=1).
- Snap held high for multiple cycles while busy sets Overrun on every cycle; the flag remains just 1.
- Busy is 1 from the cycle after an accepted Snap through the cycle the SUM byte is accepted.

Decomposition:
- Shared package holds:
  - state enum {IDLE,HDR,DATA,SUM}
  - HEADER default constant
  - frame-length constant 2*NB+2
- Sub-module snap_byte_sel: combinational selection of byte k from the 2*CNT_W shadow.
- FSM, index counter, checksum and handshake stay in the top module.

Test Plan:
- Count0=64'h3, Count1=64'h1, Snap pulse, Ready=1 -> 18 consecutive bytes A5,03,00×7,01,00×7,02. Last only on byte 18; Busy drops the cycle after.
- Count0=64'h0123456789ABCDEF, Count1=64'hFEDCBA9876543210, Ready toggling 1010… -> bytes EF,CD,AB,89,67,45,23,01,10,32,54,76,98,BA,DC,FE, checksum 00. Data held stable during every Ready=0 cycle.
- Snap, then counters change every cycle during the frame -> frame carries only the values present on the Snap cycle.
- Snap at byte 5 of a frame -> frame unaffected, Overrun=1. ClrOvr pulse -> Overrun=0. ClrOvr coincident with a dropped Snap -> Overrun stays 1.
- Snap asserted on the cycle the checksum byte is accepted -> next cycle Valid=1 with Data=A5 and new counter values latched; Overrun=0.
- Reset asserted at byte 9 with Ready=1 -> next cycle Valid=0, Busy=0, Overrun=0. A following Snap starts a fresh frame with A5.
